// File: rtl/id_ex_pipe_buffer.sv
// Decode/execute pipeline buffer: DEPTH-entry circular FIFO of decoded bundles with
// valid/ready handshake, flush-to-bubble, occupancy output and a saturating stall counter.
module id_ex_pipe_buffer #(
    parameter int XLEN    = 32,
    parameter int CTRL_W  = 5,
    parameter int CMD_W   = 4,
    parameter int REG_W   = 4,
    parameter int IMM_W   = 24,
    parameter int SHOP_W  = 12,
    parameter int DEPTH   = 2,
    parameter int STALL_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [CTRL_W-1:0]        in_ctrl,
    input  logic [CMD_W-1:0]         in_cmd,
    input  logic [XLEN-1:0]          in_pc,
    input  logic [XLEN-1:0]          in_rn,
    input  logic [XLEN-1:0]          in_rm,
    input  logic                     in_imm,
    input  logic [SHOP_W-1:0]        in_shop,
    input  logic [IMM_W-1:0]         in_simm,
    input  logic [REG_W-1:0]         in_dest,
    input  logic [3:0]               in_status,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CTRL_W-1:0]        out_ctrl,
    output logic [CMD_W-1:0]         out_cmd,
    output logic [XLEN-1:0]          out_pc,
    output logic [XLEN-1:0]          out_rn,
    output logic [XLEN-1:0]          out_rm,
    output logic                     out_imm,
    output logic [SHOP_W-1:0]        out_shop,
    output logic [IMM_W-1:0]         out_simm,
    output logic [REG_W-1:0]         out_dest,
    output logic [3:0]               out_status,
    output logic [$clog2(DEPTH):0]   count,
    output logic [STALL_W-1:0]       stall_cnt
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [CMD_W-1:0]  cmd;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   rn;
        logic [XLEN-1:0]   rm;
        logic              imm;
        logic [SHOP_W-1:0] shop;
        logic [IMM_W-1:0]  simm;
        logic [REG_W-1:0]  dest;
        logic [3:0]        status;
    } entry_t;

    entry_t           mem [DEPTH];
    entry_t           in_entry;
    entry_t           head;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             push;
    logic             pop;
    logic             stall;

    assign in_entry = '{ctrl: in_ctrl, cmd: in_cmd, pc: in_pc, rn: in_rn, rm: in_rm,
                         imm: in_imm, shop: in_shop, simm: in_simm, dest: in_dest,
                         status: in_status};

    // Readiness depends only on registered occupancy: a full buffer never accepts,
    // even if EX pops in the same cycle, which keeps in_ready off any combinational path.
    assign in_ready  = (count < CNT_W'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;
    assign stall     = in_valid & ~in_ready & ~flush;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_entry;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count     <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            stall_cnt <= '0;
        end else begin
            if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + STALL_W'(1);
            if (flush) begin
                count  <= '0;
                rd_ptr <= wr_ptr;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
                case ({push, pop})
                    2'b10:   count <= count + CNT_W'(1);
                    2'b01:   count <= count - CNT_W'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    // An empty buffer presents a bubble: control bits zero so EX does nothing.
    assign head       = mem[rd_ptr];
    assign out_ctrl   = out_valid ? head.ctrl : '0;
    assign out_cmd    = head.cmd;
    assign out_pc     = head.pc;
    assign out_rn     = head.rn;
    assign out_rm     = head.rm;
    assign out_imm    = head.imm;
    assign out_shop   = head.shop;
    assign out_simm   = head.simm;
    assign out_dest   = head.dest;
    assign out_status = head.status;
endmodule

// File: doc/id_ex_pipe_buffer.md
Name: id_ex_pipe_buffer

Overview:
- Parametrised successor to the single-entry decode/execute pipeline register.
- Holds decoded instruction bundles (control bits, PC, operand values, shift/immediate fields, destination, status) in a DEPTH-entry circular buffer between ID and EX.
- Adds a valid/ready handshake, backpressure from EX, flush with bubble insertion, occupancy reporting and a saturating stall counter.
- Lets ID keep decoding while EX is frozen (multi-cycle ops, memory wait).

Parameters:
- XLEN, 32, width of PC and operand values (Val_Rn, Val_Rm)
- CTRL_W, 5, control bit vector {wb_en, mem_r_en, mem_w_en, branch_en, S}; zeroed on bubble/flush
- CMD_W, 4, execute command width
- REG_W, 4, destination register index width
- IMM_W, 24, signed branch immediate width
- SHOP_W, 12, shift-operand width
- DEPTH, 2, buffer entries; power of two, >=2
- STALL_W, 16, stall counter width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-low reset
- flush  in  1  discard all held and incoming bundles this cycle
- in_valid  in  1  ID presents a bundle
- in_ready  out  1  buffer can accept
- in_ctrl  in  CTRL_W  control bits
- in_cmd  in  CMD_W  exec command
- in_pc  in  XLEN  PC+4 of instruction
- in_rn, in_rm  in  XLEN each  operand values
- in_imm  in  1  immediate flag
- in_shop  in  SHOP_W  shift operand
- in_simm  in  IMM_W  signed immediate
- in_dest  in  REG_W  destination register
- in_status  in  4  NZCV flags
- out_valid  out  1  head bundle valid
- out_ready  in  1  EX consumes head
- out_ctrl, out_cmd, out_pc, out_rn, out_rm, out_imm, out_shop, out_simm, out_dest, out_status  out  matching in_* widths  head bundle
- count  out  $clog2(DEPTH)+1  occupancy
- stall_cnt  out  STALL_W  saturating backpressure cycle count

Behaviour:
- Reset is sampled on the clk edge with rst==0. It clears count, rd_ptr, wr_ptr and stall_cnt, and gives out_valid=0 and out_ctrl=0. Storage contents are don't-care. Reset mid-stream discards everything.
- in_ready = (count < DEPTH). It is combinational from registered count only. There is no full-with-pop pass-through.
- push = in_valid & in_ready & ~flush.
- pop = out_valid & out_ready & ~flush.
- out_valid = (count != 0).
- Outputs are driven from the entry at rd_ptr.
- When count==0, out_ctrl is forced to 0 (bubble: no writeback, no memory access, no branch, no S). Other out_* fields are don't-care.
- Latency: a bundle pushed at edge N appears on the outputs with out_valid=1 after edge N. This gives 1 cycle, matching the legacy register when EX never stalls.
- Simultaneous push and pop: count unchanged, both pointers advance. Legal whenever count>=1 and count<DEPTH.
- Pointers wrap modulo DEPTH.
- Order is strictly FIFO. No entry is overwritten while held.
- flush=1 at an edge:
  - count<=0 and rd_ptr<=wr_ptr.
  - Any coincident push is dropped and any coincident pop does not count as a consumption.
  - The next cycle has out_valid=0 and out_ctrl=0.
  - flush overrides everything except reset.
- Stall counter: increments by 1 at each edge where in_valid & ~in_ready & ~flush. It saturates at 2^STALL_W-1. It is not cleared by flush.
- Never-do rules: no push when count==DEPTH; no pop when count==0. Both are guaranteed by the push/pop gating, so illegal stimulus is silently ignored.
- in_status is captured per entry, so each bundle carries the flags sampled when it was decoded.

Test Plan:
- Streaming: out_ready=1, push 8 bundles with in_pc=4,8,...,32 on consecutive cycles.
  - Each appears 1 cycle later in order.
  - count stays 1 and in_ready stays 1.
- Backpressure: out_ready=0, push PCs 0x10, 0x14, 0x18.
  - First two are accepted, count=2, in_ready=0.
  - stall_cnt increments each cycle the third waits.
  - Release out_ready; the bundles drain as 0x10, 0x14, 0x18.
- Flush while full plus push: count=2, assert flush with in_valid=1.
  - Next cycle count=0, out_valid=0, out_ctrl=5'b0.
  - The flushed-cycle bundle never appears.
- Wrap-around with DEPTH=4: alternate 3 pushes / 2 pops over 20 cycles with a random out_ready pattern.
  - Output sequence equals input sequence.
  - count never exceeds 4.
- Saturation with STALL_W=4: hold in_valid=1, in_ready=0 for 20 cycles.
  - stall_cnt reaches 15 and holds.
- Reset mid-operation: count=2, drive rst=0 for one edge.
  - count=0, out_valid=0, out_ctrl=0, stall_cnt=0.
  - A push on the following cycle appears normally.
